// File: rtl/net_tx_arbiter.sv
// Packet-atomic round-robin arbiter merging NUM_PORTS AXI-Stream requesters
// onto one registered 10G MAC TX stream, with per-port packet counters.
module net_tx_arbiter #(
   parameter  int unsigned NUM_PORTS  = 2,
   parameter  int unsigned DATA_WIDTH = 64,
   parameter  int unsigned CNT_WIDTH  = 32,
   localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
   localparam int unsigned GW         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                            clk156,
   input  logic                            aresetn,
   input  logic                            link_up,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
   input  logic [NUM_PORTS*KEEP_WIDTH-1:0] s_tkeep,
   input  logic [NUM_PORTS-1:0]            s_tlast,
   input  logic [NUM_PORTS-1:0]            s_tvalid,
   output logic [NUM_PORTS-1:0]            s_tready,
   output logic [DATA_WIDTH-1:0]           m_tdata,
   output logic [KEEP_WIDTH-1:0]           m_tkeep,
   output logic                            m_tlast,
   output logic                            m_tvalid,
   input  logic                            m_tready,
   output logic [GW-1:0]                   grant_id,
   output logic                            busy,
   output logic [NUM_PORTS*CNT_WIDTH-1:0]  pkt_count
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   logic [0:0]            state, state_nxt;
   logic [GW-1:0]         last_grant, last_grant_nxt, grant_nxt;
   logic [GW-1:0]         win;
   logic                  win_vld;
   logic                  load_grant;
   logic                  out_free;
   logic                  sel_valid, sel_last;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [KEEP_WIDTH-1:0] sel_keep;
   logic                  accept, last_beat;

   // Output register can take a new beat when empty or draining this cycle
   assign out_free  = ~m_tvalid | m_tready;
   assign accept    = (state == ST_BUSY) && sel_valid && out_free;
   assign last_beat = accept && sel_last;
   assign busy      = (state == ST_BUSY);

   // Round-robin search starting one past the last granted port
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      for (int k = 0; k < int'(NUM_PORTS); k++) begin
         for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (!win_vld && s_tvalid[i] &&
                ((int'(last_grant) + 1 + k) % int'(NUM_PORTS)) == i) begin
               win     = GW'(i);
               win_vld = 1'b1;
            end
         end
      end
   end

   // Selected requester mux and ready fan-out
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      sel_keep  = '0;
      s_tready  = '0;
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
         if (grant_id == GW'(i)) begin
            sel_valid   = s_tvalid[i];
            sel_last    = s_tlast[i];
            sel_data    = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            sel_keep    = s_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
            s_tready[i] = (state == ST_BUSY) && out_free;
         end
      end
   end

   // Next-state: grant from IDLE, or re-grant at the tlast edge without a bubble
   always_comb begin
      state_nxt      = state;
      grant_nxt      = grant_id;
      last_grant_nxt = last_grant;
      load_grant     = link_up && win_vld && ((state == ST_IDLE) || last_beat);
      case (state)
         ST_IDLE: if (load_grant) state_nxt = ST_BUSY;
         ST_BUSY: if (last_beat)  state_nxt = load_grant ? ST_BUSY : ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
      if (load_grant) begin
         grant_nxt      = win;
         last_grant_nxt = win;
      end
   end

   always_ff @(posedge clk156 or negedge aresetn) begin
      if (!aresetn) begin
         state      <= ST_IDLE;
         grant_id   <= '0;
         last_grant <= GW'(NUM_PORTS - 1);
      end else begin
         state      <= state_nxt;
         grant_id   <= grant_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   // Output beat register: load on accept, hold under backpressure
   always_ff @(posedge clk156 or negedge aresetn) begin
      if (!aresetn) begin
         m_tvalid <= 1'b0;
         m_tlast  <= 1'b0;
         m_tdata  <= '0;
         m_tkeep  <= '0;
      end else if (accept) begin
         m_tvalid <= 1'b1;
         m_tlast  <= sel_last;
         m_tdata  <= sel_data;
         m_tkeep  <= sel_keep;
      end else if (m_tready) begin
         m_tvalid <= 1'b0;
      end
   end

   always_ff @(posedge clk156 or negedge aresetn) begin
      if (!aresetn) begin
         pkt_count <= '0;
      end else begin
         for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (last_beat && grant_id == GW'(i))
               pkt_count[i*CNT_WIDTH +: CNT_WIDTH] <=
                  pkt_count[i*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
         end
      end
   end

endmodule
